// File: rtl/spi_gen_pkg.sv
// Shared types for the SPI slave: FSM state encoding, command codes and a
// helper that identifies the bit-receiving states.
package spi_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA
    } spi_state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic logic is_shift_state(input spi_state_t s);
        return (s == ST_WRITE) || (s == ST_READ_ADD) || (s == ST_READ_DATA);
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-response shifter: load_i stores a payload, go_i starts shifting it out
// MSB first; done_o stays high until clr_i once all DATA_W bits have gone.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              go_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sh_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (clr_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (go_i && !active_q && !done_q) begin
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == LAST_BIT) begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Payload register carries no reset; miso is gated by active_q instead.
    always_ff @(posedge clk) begin
        if (active_q) begin
            sh_q <= {sh_q[DATA_W-2:0], 1'b0};
        end else if (load_i) begin
            sh_q <= data_i;
        end
    end

    assign miso_o = active_q & sh_q[DATA_W-1];
    assign done_o = done_q;

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: direction bit plus FRAME_W-bit receive, read response via
// spi_tx_shifter. Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output.
module spi_slave_gen
    import spi_gen_pkg::*;
#(
    parameter  int DATA_W  = 8,
    localparam int FRAME_W = DATA_W + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

    spi_state_t         state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               rd_pend_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               tx_latched_q;

    logic rx_done;
    logic tx_awaited;
    logic sh_load;
    logic sh_go;
    logic sh_clr;
    logic sh_done;

    assign rx_done    = (bit_cnt_q == FRAME_CNT);
    assign tx_awaited = (state_q == ST_READ_DATA) && !ss_n;
    // First tx_valid of the frame is taken; early ones wait for rx_done to start.
    assign sh_load    = tx_awaited && !tx_latched_q && tx_valid;
    assign sh_go      = tx_awaited && rx_done && !sh_done && (tx_latched_q || tx_valid);
    assign sh_clr     = ss_n || (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_latched_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (ss_n) begin
                state_q      <= ST_IDLE;
                bit_cnt_q    <= '0;
                tx_latched_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_CHK_CMD;
                        bit_cnt_q    <= '0;
                        tx_latched_q <= 1'b0;
                    end
                    ST_CHK_CMD: begin
                        if (!mosi) begin
                            state_q <= ST_WRITE;
                        end else if (!rd_pend_q) begin
                            state_q   <= ST_READ_ADD;
                            rd_pend_q <= 1'b1;
                        end else begin
                            state_q   <= ST_READ_DATA;
                            rd_pend_q <= 1'b0;
                        end
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        if (!rx_done) begin
                            rx_data_q  <= {rx_data_q[FRAME_W-2:0], mosi};
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            rx_valid_q <= (bit_cnt_q == FRAME_CNT - 1'b1);
                        end
                        if (sh_load) begin
                            tx_latched_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sh_clr),
        .load_i (sh_load),
        .go_i   (sh_go),
        .data_i (tx_data),
        .miso_o (miso),
        .done_o (sh_done)
    );

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= ss_n && is_shift_state(state_q)
                           && (!rx_done || (tx_latched_q && !sh_done));
        end
    end

    assign frame_err = frame_err_q;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: an 8-bit and a 16-bit instance share
// clock and reset; each task drives one scenario and checks it inline.
module tb_spi_slave_gen;
    import spi_gen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       ss_n, mosi, miso, rx_valid, tx_valid, busy;
    logic [9:0] rx_data;
    logic [7:0] tx_data;

    logic        ss2_n, mosi2, miso2, rx_valid2, tx_valid2, busy2;
    logic [17:0] rx_data2;
    logic [15:0] tx_data2;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err, frame_err2;
`endif

    int checks = 0;
    int errors = 0;

    spi_slave_gen #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    spi_slave_gen #(.DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss2_n), .mosi(mosi2), .miso(miso2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .busy(busy2)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err2)
`endif
    );

    task automatic drive(input bit sel, input logic s, input logic m);
        @(negedge clk);
        if (sel) begin
            ss2_n = s;
            mosi2 = m;
        end else begin
            ss_n = s;
            mosi = m;
        end
    endtask

    // Leaves the bench at the negedge of the CHK_CMD cycle with dir on mosi.
    task automatic start_frame(input bit sel, input logic dir);
        drive(sel, 1'b0, 1'b0);
        drive(sel, 1'b0, dir);
    endtask

    task automatic send_word(input bit sel, input logic dir, input logic [17:0] w, input int n);
        start_frame(sel, dir);
        for (int i = n - 1; i >= 0; i--) drive(sel, 1'b0, w[i]);
    endtask

    task automatic end_frame(input bit sel);
        drive(sel, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rx_valid, miso, rx_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset8: busy/rx_valid/miso/rx_data=%b required 0", {busy, rx_valid, miso, rx_data});
        end
        checks++;
        if ({busy2, rx_valid2, miso2, rx_data2} !== 21'd0) begin
            errors++;
            $display("FAIL reset16: busy/rx_valid/miso/rx_data=%b required 0", {busy2, rx_valid2, miso2, rx_data2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic [9:0] w;
        w = 10'h0A5;
        start_frame(1'b0, 1'b0);
        checks++;
        if (dut.state_q !== ST_CHK_CMD || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_chk: state=%0d busy=%b required CHK_CMD busy=1", dut.state_q, busy);
        end
        for (int i = 9; i >= 0; i--) begin
            drive(1'b0, 1'b0, w[i]);
            checks++;
            if (rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_early_valid: bit %0d rx_valid=%b required 0", i, rx_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h0A5) begin
            errors++;
            $display("FAIL wr_word: rx_valid=%b rx_data=%h required 1 0a5", rx_valid, rx_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            checks++;
            if (rx_valid !== 1'b0 || rx_data !== 10'h0A5) begin
                errors++;
                $display("FAIL wr_hold: rx_valid=%b rx_data=%h required 0 0a5", rx_valid, rx_data);
            end
        end
        end_frame(1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dut.rd_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL wr_end: busy=%b rd_pend=%b required 0 0", busy, dut.rd_pend_q);
        end
    endtask

    task automatic test_read_addr;
        send_word(1'b0, 1'b1, 18'h0020F, 10);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h20F || dut.rd_pend_q !== 1'b1
            || dut.state_q !== ST_READ_ADD) begin
            errors++;
            $display("FAIL rd_addr: rx_valid=%b rx_data=%h rd_pend=%b state=%0d required 1 20f 1 READ_ADD",
                     rx_valid, rx_data, dut.rd_pend_q, dut.state_q);
        end
        end_frame(1'b0);
        @(negedge clk);
    endtask

    task automatic test_read_data;
        logic [7:0] exp;
        exp = 8'hC3;
        send_word(1'b0, 1'b1, 18'h003A5, 10);
        checks++;
        if (dut.state_q !== ST_READ_DATA || dut.rd_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL rd_enter: state=%0d rd_pend=%b required READ_DATA 0", dut.state_q, dut.rd_pend_q);
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h3A5 || miso !== 1'b0) begin
            errors++;
            $display("FAIL rd_word: rx_valid=%b rx_data=%h miso=%b required 1 3a5 0", rx_valid, rx_data, miso);
        end
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            tx_valid = (i == 4);
            tx_data  = (i == 4) ? 8'h00 : 8'hC3;
            checks++;
            if (miso !== exp[i]) begin
                errors++;
                $display("FAIL rd_miso: bit %0d miso=%b required %b", i, miso, exp[i]);
            end
        end
        tx_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (miso !== 1'b0) begin
                errors++;
                $display("FAIL rd_tail: miso=%b required 0", miso);
            end
        end
        end_frame(1'b0);
        @(negedge clk);
    endtask

    task automatic test_abort;
        start_frame(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
        end_frame(1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || miso !== 1'b0 || dut.rd_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b rx_valid=%b miso=%b rd_pend=%b required 0 0 0 0",
                     busy, rx_valid, miso, dut.rd_pend_q);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_err: frame_err=%b required 1", frame_err);
        end
`endif
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_late: rx_valid=%b required 0", rx_valid);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_len: frame_err=%b required 0", frame_err);
        end
`endif
    endtask

    task automatic test_preload_reset;
        logic [9:0] w;
        w = 10'h3F0;
        send_word(1'b0, 1'b1, 18'h002AA, 10);
        @(negedge clk);
        end_frame(1'b0);
        @(negedge clk);
        checks++;
        if (dut.rd_pend_q !== 1'b1) begin
            errors++;
            $display("FAIL pre_pend: rd_pend=%b required 1", dut.rd_pend_q);
        end
        start_frame(1'b0, 1'b1);
        for (int i = 9; i >= 0; i--) begin
            drive(1'b0, 1'b0, w[i]);
            tx_valid = (i == 6);
            tx_data  = (i == 6) ? 8'hA5 : 8'h00;
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || miso !== 1'b0) begin
            errors++;
            $display("FAIL pre_strobe: rx_valid=%b miso=%b required 1 0", rx_valid, miso);
        end
        @(negedge clk);
        checks++;
        if (miso !== 1'b1) begin
            errors++;
            $display("FAIL pre_b7: miso=%b required 1", miso);
        end
        @(negedge clk);
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL pre_b6: miso=%b required 0", miso);
        end
        @(negedge clk);
        checks++;
        if (miso !== 1'b1) begin
            errors++;
            $display("FAIL pre_b5: miso=%b required 1", miso);
        end
        #2 rst_n = 1'b0;
        ss_n = 1'b1;
        #1;
        checks++;
        if (miso !== 1'b0 || dut.rd_pend_q !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: miso=%b rd_pend=%b busy=%b rx_valid=%b required 0 0 0 0",
                     miso, dut.rd_pend_q, busy, rx_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (dut.state_q !== ST_CHK_CMD) begin
            errors++;
            $display("FAIL rst_next: state=%0d required CHK_CMD", dut.state_q);
        end
        end_frame(1'b0);
        @(negedge clk);
    endtask

    task automatic test_wide;
        logic [15:0] exp;
        exp = 16'hBEEF;
        send_word(1'b1, 1'b1, 18'h21234, 18);
        @(negedge clk);
        checks++;
        if (rx_valid2 !== 1'b1 || rx_data2 !== 18'h21234) begin
            errors++;
            $display("FAIL w16_addr: rx_valid=%b rx_data=%h required 1 21234", rx_valid2, rx_data2);
        end
        end_frame(1'b1);
        @(negedge clk);
        send_word(1'b1, 1'b1, 18'h30000, 18);
        @(negedge clk);
        checks++;
        if (rx_valid2 !== 1'b1 || rx_data2 !== 18'h30000) begin
            errors++;
            $display("FAIL w16_word: rx_valid=%b rx_data=%h required 1 30000", rx_valid2, rx_data2);
        end
        tx_valid2 = 1'b1;
        tx_data2  = 16'hBEEF;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            tx_valid2 = 1'b0;
            checks++;
            if (miso2 !== exp[i]) begin
                errors++;
                $display("FAIL w16_miso: bit %0d miso=%b required %b", i, miso2, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (miso2 !== 1'b0) begin
            errors++;
            $display("FAIL w16_tail: miso=%b required 0", miso2);
        end
        end_frame(1'b1);
        @(negedge clk);
    endtask

    initial begin
        ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        ss2_n = 1'b1; mosi2 = 1'b0; tx_valid2 = 1'b0; tx_data2 = '0;
        test_reset;
        test_write;
        test_read_addr;
        test_read_data;
        test_abort;
        test_preload_reset;
        test_wide;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
